// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared processor types for fetch, memory and interpreter
// Purpose: address/instruction widths, fetch FSM state encoding and PC helpers.
// Ports: none (package).
package fetch_unit_pkg;

  localparam int ADDR_W = 4;
  localparam int INST_W = 16;
  localparam int LAT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALT
  } fetch_state_t;

  // One bit wider than the PC so that PROG_LEN=16 is representable.
  typedef logic [ADDR_W:0] pc_ext_t;

  // True when the instruction at pc is the last one of the program.
  function automatic logic pc_at_end(input logic [ADDR_W-1:0] pc, input int prog_len);
    return (pc_ext_t'({1'b0, pc}) + pc_ext_t'(1)) == pc_ext_t'(prog_len);
  endfunction

  function automatic logic pc_in_range(input logic [ADDR_W-1:0] pc, input int prog_len);
    return pc_ext_t'({1'b0, pc}) < pc_ext_t'(prog_len);
  endfunction

endpackage

// File: rtl/fetch_unit_lat_counter.sv
// rtl/fetch_unit_lat_counter.sv - memory latency down-counter for the fetch unit
// Purpose: loaded with the memory latency when a request issues, counts down
//          while waiting; o_done marks the cycle whose read data is valid.
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_load         load i_load_val (takes priority over i_dec)
//   i_load_val     latency value
//   i_dec          decrement (saturates at zero)
//   o_done         count == 1
module fetch_lat_counter
  import fetch_unit_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [LAT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - LAT_W'(1);
    end
  end

  assign o_done = (r_count == LAT_W'(1));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with fixed-latency ROM and redirect
// Purpose: fetches PROG_LEN instructions from a ROM of latency MEM_LAT and hands
//          each to the interpreter with a valid/ready handshake.
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_start                   begin fetching at address 0 (IDLE only)
//   o_mem_en, o_mem_addr      ROM read request
//   i_mem_data                ROM read data
//   o_inst, o_inst_pc         fetched instruction and its address
//   o_inst_valid, i_inst_ready  instruction handshake
//   i_redirect_valid, i_redirect_pc  load a new PC
//   o_halted                  program complete
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PROG_LEN = 9,
  parameter int MEM_LAT  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [INST_W-1:0] i_mem_data,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_halted
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_inst_valid;
  logic              r_halted;

  logic              w_lat_done;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_pc_next = r_pc + ADDR_W'(1);

  fetch_lat_counter u_lat_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (r_state == S_REQ),
    .i_load_val (LAT_W'(MEM_LAT)),
    .i_dec      (r_state == S_WAIT),
    .o_done     (w_lat_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else if (i_redirect_valid && (r_state != S_IDLE)) begin
      // Redirect wins over everything outside IDLE; any pending capture is
      // dropped. A handshake in the same cycle still consumes the instruction
      // because inst_valid falls here.
      r_pc         <= i_redirect_pc;
      r_mem_addr   <= i_redirect_pc;
      r_inst_valid <= 1'b0;
      if (pc_in_range(i_redirect_pc, PROG_LEN)) begin
        r_state  <= S_REQ;
        r_mem_en <= 1'b1;
        r_halted <= 1'b0;
      end else begin
        r_state  <= S_HALT;
        r_mem_en <= 1'b0;
        r_halted <= 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_mem_en   <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_lat_done) begin
            r_inst       <= i_mem_data;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_mem_en     <= 1'b0;
            r_state      <= S_VALID;
          end
        end
        S_VALID: begin
          if (i_inst_ready) begin
            r_inst_valid <= 1'b0;
            r_pc         <= w_pc_next;
            r_mem_addr   <= w_pc_next;
            if (pc_at_end(r_pc, PROG_LEN)) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state  <= S_REQ;
              r_mem_en <= 1'b1;
            end
          end
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_en     = r_mem_en;
  assign o_mem_addr   = r_mem_addr;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_inst_valid = r_inst_valid;
  assign o_halted     = r_halted;

endmodule
